mux4_rr_arbiter: RTL and testbench

//  Round-robin controller for the 4:1 mux tree.
//  - Shares one WIDTH-bit mux between 4 requesters.
//  - Drives the tree selects sel1 (pair select) and sel2 (pair-of-pairs select).
//  - Issues one-hot grants, caps each tenure at MAX_BURST cycles and registers the muxed data.
//  - Sits between requesting sources and a single downstream consumer.

---
 rtl/mux4_rr_arbiter_pkg.sv | 27 ++
 rtl/mux4_rr_arbiter_bus.sv | 21 ++
 rtl/mux4_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 round-robin mux arbiter: state encoding,
// requester count and the rotating-priority pick function.
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns {found, idx}: first set req bit scanning ptr, ptr+1, ... mod NREQ.
  // Scanning from the farthest offset down lets the nearest hit overwrite.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IDXW-1:0] ptr);
    logic [IDXW:0]   pick;
    logic [IDXW-1:0] idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDXW'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_bus.sv
// WIDTH-wide 4:1 mux built as two levels of 2:1 stages; purely combinational.
module mux4_bus #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic             sel1_i,
  input  logic             sel2_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;

  assign lo_pair = sel1_i ? in1_i : in0_i;
  assign hi_pair = sel1_i ? in3_i : in2_i;
  assign out_o   = sel2_i ? hi_pair : lo_pair;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin controller for a shared 4:1 mux tree: one-hot grants capped at
// MAX_BURST cycles per tenure, registered mux output with one cycle latency.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [NREQ-1:0]  gnt,
  output logic             sel1,
  output logic             sel2,
  output logic [WIDTH-1:0] mux_out,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_src,
  output logic             busy
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [3:0]      burst_q, burst_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] mux_out_q, mux_out_d;
  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  out_src_q, out_src_d;

  logic [WIDTH-1:0] bus_data;
  logic             xfer;
  logic             release_g;
  logic [IDXW-1:0]  scan_ptr;
  logic [IDXW:0]    pick;

  // Selects come straight from the grant index register, so the tree only
  // moves on edges that also move the grant.
  mux4_bus #(.WIDTH(WIDTH)) u_bus (
    .in0_i  (in_0),
    .in1_i  (in_1),
    .in2_i  (in_2),
    .in3_i  (in_3),
    .sel1_i (gidx_q[0]),
    .sel2_i (gidx_q[1]),
    .out_o  (bus_data)
  );

  always_comb begin
    xfer      = (state_q == ST_GRANT) && req[gidx_q];
    release_g = (state_q == ST_GRANT) && (!req[gidx_q] || (burst_q == BURST_MAX));
    // On release the scan starts just past the current holder.
    scan_ptr  = (state_q == ST_GRANT) ? gidx_q + IDXW'(1) : ptr_q;
    pick      = rr_pick(req, scan_ptr);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    burst_d     = burst_q;
    gnt_d       = gnt_q;
    mux_out_d   = mux_out_q;
    out_src_d   = out_src_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick[IDXW]) begin
          state_d = ST_GRANT;
          gidx_d  = pick[IDXW-1:0];
          gnt_d   = NREQ'(1) << pick[IDXW-1:0];
          burst_d = 4'd1;
        end
      end
      ST_GRANT: begin
        if (release_g) begin
          ptr_d = scan_ptr;
          if (pick[IDXW]) begin
            gidx_d  = pick[IDXW-1:0];
            gnt_d   = NREQ'(1) << pick[IDXW-1:0];
            burst_d = 4'd1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            burst_d = 4'd0;
          end
        end else if (burst_q != BURST_MAX) begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (xfer) begin
      mux_out_d   = bus_data;
      out_valid_d = 1'b1;
      out_src_d   = gidx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      burst_q     <= '0;
      gnt_q       <= '0;
      mux_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      burst_q     <= burst_d;
      gnt_q       <= gnt_d;
      mux_out_q   <= mux_out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel1      = gidx_q[0];
  assign sel2      = gidx_q[1];
  assign mux_out   = mux_out_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a MAX_BURST=4 instance and a
// MAX_BURST=1 instance, each with a scoreboard of expected {src, data} words.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] req = '0;
  logic [7:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic [3:0] gnt;
  logic       sel1, sel2, out_valid, busy;
  logic [7:0] mux_out;
  logic [1:0] out_src;

  logic [3:0] reqb = '0;
  logic [7:0] inb_0 = '0, inb_1 = '0, inb_2 = '0, inb_3 = '0;
  logic [3:0] gntb;
  logic       sel1b, sel2b, out_validb, busyb;
  logic [7:0] mux_outb;
  logic [1:0] out_srcb;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb0[$];
  logic [9:0] sb1[$];
  logic [9:0] exp0, exp1;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .gnt(gnt), .sel1(sel1), .sel2(sel2), .mux_out(mux_out),
    .out_valid(out_valid), .out_src(out_src), .busy(busy)
  );

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .req(reqb),
    .in_0(inb_0), .in_1(inb_1), .in_2(inb_2), .in_3(inb_3),
    .gnt(gntb), .sel1(sel1b), .sel2(sel2b), .mux_out(mux_outb),
    .out_valid(out_validb), .out_src(out_srcb), .busy(busyb)
  );

  // Scoreboard consumers: every valid output word must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected: got src=%0d data=%h, required no output", out_src, mux_out);
      end else begin
        exp0 = sb0.pop_front();
        if ({out_src, mux_out} !== exp0) begin
          errors++;
          $display("FAIL sb0_word: got src=%0d data=%h, required src=%0d data=%h",
                   out_src, mux_out, exp0[9:8], exp0[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_validb === 1'b1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got src=%0d data=%h, required no output", out_srcb, mux_outb);
      end else begin
        exp1 = sb1.pop_front();
        if ({out_srcb, mux_outb} !== exp1) begin
          errors++;
          $display("FAIL sb1_word: got src=%0d data=%h, required src=%0d data=%h",
                   out_srcb, mux_outb, exp1[9:8], exp1[7:0]);
        end
      end
    end
  end

  task automatic apply_reset;
    rst  = 1'b1;
    req  = '0;
    reqb = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'hF;
    in_0 = 8'h11; in_1 = 8'h22; in_2 = 8'h33; in_3 = 8'h44;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (mux_out !== 8'h00) begin errors++; $display("FAIL reset_mux_out: got %h, required 00", mux_out); end
    checks++;
    if ({busy, sel2, sel1, out_src} !== 5'b0) begin
      errors++;
      $display("FAIL reset_misc: got busy=%b sel2=%b sel1=%b src=%0d, required all 0", busy, sel2, sel1, out_src);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b, required 0001", gnt); end
    sb0.push_back({2'd0, 8'h11});
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== 5'b0) begin errors++; $display("FAIL reset_idle: got gnt=%b busy=%b, required 0000 0", gnt, busy); end
    checks++;
    if (sb0.size() != 0) begin errors++; $display("FAIL reset_drain: got %0d pending, required 0", sb0.size()); end
  endtask

  task automatic test_single;
    apply_reset();
    in_2 = 8'hA5;
    req  = 4'b0100;
    rst  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt[%0d]: got %b, required 0100", n, gnt); end
      checks++;
      if ({sel2, sel1} !== 2'b10) begin errors++; $display("FAIL single_sel[%0d]: got %b%b, required 10", n, sel2, sel1); end
      if (n > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b, required 1", n, out_valid); end
      end
      sb0.push_back({2'd2, 8'hA5});
    end
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release: got %b, required 0000", gnt); end
    checks++;
    if (sb0.size() != 0) begin errors++; $display("FAIL single_drain: got %0d pending, required 0", sb0.size()); end
  endtask

  task automatic test_fairness;
    logic [1:0] g;
    logic [3:0] eg;
    apply_reset();
    in_0 = 8'h10; in_1 = 8'h11; in_2 = 8'h12; in_3 = 8'h13;
    req = 4'hF;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      g  = 2'(n / 4);
      eg = 4'b0001 << g;
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL fair_gnt[%0d]: got %b, required %b", n, gnt, eg); end
      checks++;
      if ($countones(gnt) > 1) begin errors++; $display("FAIL fair_onehot[%0d]: got %b, required at most one bit", n, gnt); end
      sb0.push_back({g, 8'h10 + {6'd0, g}});
    end
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_release: got %b, required 0000", gnt); end
    checks++;
    if (sb0.size() != 0) begin errors++; $display("FAIL fair_drain: got %0d pending, required 0", sb0.size()); end
  endtask

  task automatic test_early_drop;
    apply_reset();
    in_1 = 8'h5A; in_3 = 8'hC3;
    req = 4'b1010;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_gnt0: got %b, required 0010", gnt); end
    sb0.push_back({2'd1, 8'h5A});
    @(negedge clk);
    checks++;
    if ({gnt, out_valid} !== 5'b0010_1) begin errors++; $display("FAIL drop_cyc1: got gnt=%b valid=%b, required 0010 1", gnt, out_valid); end
    sb0.push_back({2'd1, 8'h5A});
    @(negedge clk);
    checks++;
    if ({gnt, out_valid} !== 5'b0010_1) begin errors++; $display("FAIL drop_dead: got gnt=%b valid=%b, required 0010 1", gnt, out_valid); end
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if ({gnt, out_valid} !== 5'b1000_0) begin errors++; $display("FAIL drop_move: got gnt=%b valid=%b, required 1000 0", gnt, out_valid); end
    sb0.push_back({2'd3, 8'hC3});
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release: got %b, required 0000", gnt); end
    checks++;
    if (sb0.size() != 0) begin errors++; $display("FAIL drop_drain: got %0d pending, required 0", sb0.size()); end
  endtask

  task automatic test_burst1;
    logic [3:0] eg;
    apply_reset();
    inb_0 = 8'h0F; inb_2 = 8'hF0;
    reqb = 4'b0101;
    rst  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      eg = (n % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (gntb !== eg) begin errors++; $display("FAIL b1_gnt[%0d]: got %b, required %b", n, gntb, eg); end
      if (n > 0) begin
        checks++;
        if (out_validb !== 1'b1) begin errors++; $display("FAIL b1_valid[%0d]: got %b, required 1", n, out_validb); end
      end
      if (n % 2 == 0) sb1.push_back({2'd0, 8'h0F});
      else            sb1.push_back({2'd2, 8'hF0});
    end
    @(negedge clk);
    reqb = 4'h0;
    @(negedge clk);
    checks++;
    if (gntb !== 4'b0000) begin errors++; $display("FAIL b1_release: got %b, required 0000", gntb); end
    checks++;
    if (sb1.size() != 0) begin errors++; $display("FAIL b1_drain: got %0d pending, required 0", sb1.size()); end
  endtask

  task automatic test_reset_mid_burst;
    apply_reset();
    in_0 = 8'h01; in_1 = 8'h02; in_2 = 8'h03; in_3 = 8'h33;
    req = 4'b0001;
    rst = 1'b0;
    @(negedge clk);
    sb0.push_back({2'd0, 8'h01});
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL rmb_grant3: got %b, required 1000", gnt); end
    sb0.push_back({2'd3, 8'h33});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, out_valid, busy, sel2, sel1, out_src} !== 10'b0) begin
      errors++;
      $display("FAIL rmb_outputs: got gnt=%b valid=%b busy=%b sel=%b%b src=%0d, required all 0",
               gnt, out_valid, busy, sel2, sel1, out_src);
    end
    checks++;
    if (mux_out !== 8'h00) begin errors++; $display("FAIL rmb_mux_out: got %h, required 00", mux_out); end
    rst = 1'b0;
    req = 4'hF;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rmb_restart: got %b, required 0001", gnt); end
    sb0.push_back({2'd0, 8'h01});
    @(negedge clk);
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rmb_release: got %b, required 0000", gnt); end
    checks++;
    if (sb0.size() != 0) begin errors++; $display("FAIL rmb_drain: got %0d pending, required 0", sb0.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_drop();
    test_burst1();
    test_reset_mid_burst();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
